// File: rtl/gpio_to_bram_intr_pkg.sv
// gpio_to_bram_intr_pkg: register offsets, AXI response codes and address decode shared by the interrupt slave
// Contents: OFF_* byte offsets, RESP_* codes, addr_sel_e decode enum, decode() helper.
package gpio_to_bram_intr_pkg;
   localparam logic [4:0] OFF_GIE = 5'h00;
   localparam logic [4:0] OFF_IER = 5'h04;
   localparam logic [4:0] OFF_ISR = 5'h08;
   localparam logic [4:0] OFF_IAR = 5'h0C;
   localparam logic [4:0] OFF_IPR = 5'h10;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [2:0] {A_GIE, A_IER, A_ISR, A_IAR, A_IPR, A_BAD} addr_sel_e;
   function automatic addr_sel_e decode(input logic [2:0] w);
      return w == OFF_GIE[4:2] ? A_GIE :
             w == OFF_IER[4:2] ? A_IER :
             w == OFF_ISR[4:2] ? A_ISR :
             w == OFF_IAR[4:2] ? A_IAR :
             w == OFF_IPR[4:2] ? A_IPR : A_BAD;
   endfunction
endpackage

// File: rtl/intr_event_detect.sv
// intr_event_detect: turns one raw interrupt source into an event (edge or level, selectable polarity)
// Ports: clk clock; rst_n sync active-low reset; src raw source; ev event (one cycle per edge, or every active cycle).
module intr_event_detect #(
   parameter bit SENS = 1'b1,
   parameter bit ACTIVE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic src,
   output logic ev
);
   if (SENS) begin : g_edge
      logic src_q, prev_q;
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            src_q <= 1'b0;
            prev_q <= 1'b0;
         end else begin
            src_q <= src;
            prev_q <= src_q;
         end
      end
      assign ev = (src_q == ACTIVE) && (prev_q != ACTIVE);
   end else begin : g_level
      assign ev = src == ACTIVE;
   end
endmodule

// File: rtl/gpio_to_bram_intr_slave.sv
// gpio_to_bram_intr_slave: AXI4-Lite interrupt controller (GIE/IER/ISR/IAR/IPR) driving a single irq
// Ports: S_AXI_INTR_ACLK clock; S_AXI_INTR_ARESETN sync active-low reset; S_AXI_INTR_AW*/W*/B*/AR*/R*
//        AXI4-Lite slave channels; intr_src raw interrupt sources; irq interrupt output to the PS.
module gpio_to_bram_intr_slave
   import gpio_to_bram_intr_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int C_NUM_OF_INTR = 1,
   parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
   parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFFFFFF,
   parameter bit C_IRQ_SENSITIVITY = 1'b1,
   parameter bit C_IRQ_ACTIVE_STATE = 1'b1
) (
   input  logic                              S_AXI_INTR_ACLK,
   input  logic                              S_AXI_INTR_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_INTR_AWADDR,
   input  logic [2:0]                        S_AXI_INTR_AWPROT,
   input  logic                              S_AXI_INTR_AWVALID,
   output logic                              S_AXI_INTR_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_INTR_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_INTR_WSTRB,
   input  logic                              S_AXI_INTR_WVALID,
   output logic                              S_AXI_INTR_WREADY,
   output logic [1:0]                        S_AXI_INTR_BRESP,
   output logic                              S_AXI_INTR_BVALID,
   input  logic                              S_AXI_INTR_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_INTR_ARADDR,
   input  logic [2:0]                        S_AXI_INTR_ARPROT,
   input  logic                              S_AXI_INTR_ARVALID,
   output logic                              S_AXI_INTR_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_INTR_RDATA,
   output logic [1:0]                        S_AXI_INTR_RRESP,
   output logic                              S_AXI_INTR_RVALID,
   input  logic                              S_AXI_INTR_RREADY,
   input  logic [C_NUM_OF_INTR-1:0]          intr_src,
   output logic                              irq
);
   localparam logic [31:0] VMASK = (C_NUM_OF_INTR >= 32) ? 32'hFFFFFFFF : ((32'h1 << C_NUM_OF_INTR) - 32'h1);
   logic aw_full, w_full, bvalid, rvalid, gie, irq_q, term_q, commit, term, ar_hs, unused_ok;
   logic [2:0] aw_word;
   logic [3:0] w_strb;
   logic [1:0] bresp, rresp;
   logic [31:0] w_data, ier, isr, ev32, wmask, clr, rd_val, rdata;
   logic [C_NUM_OF_INTR-1:0] ev;
   addr_sel_e wsel, rsel;
   for (genvar i = 0; i < C_NUM_OF_INTR; i++) begin : g_src
      intr_event_detect #(
         .SENS(C_INTR_SENSITIVITY[i]),
         .ACTIVE(C_INTR_ACTIVE_STATE[i])
      ) u_det (
         .clk(S_AXI_INTR_ACLK),
         .rst_n(S_AXI_INTR_ARESETN),
         .src(intr_src[i]),
         .ev(ev[i])
      );
   end
   // Ready lines are forced low while reset is held, not just after the first edge.
   assign S_AXI_INTR_AWREADY = S_AXI_INTR_ARESETN & ~aw_full & ~bvalid;
   assign S_AXI_INTR_WREADY = S_AXI_INTR_ARESETN & ~w_full & ~bvalid;
   assign S_AXI_INTR_ARREADY = S_AXI_INTR_ARESETN & ~rvalid;
   assign S_AXI_INTR_BVALID = bvalid;
   assign S_AXI_INTR_BRESP = bresp;
   assign S_AXI_INTR_RVALID = rvalid;
   assign S_AXI_INTR_RRESP = rresp;
   assign S_AXI_INTR_RDATA = rdata;
   assign irq = irq_q;
   assign commit = aw_full & w_full & ~bvalid;
   assign wsel = decode(aw_word);
   assign rsel = decode(S_AXI_INTR_ARADDR[4:2]);
   assign ar_hs = S_AXI_INTR_ARVALID & S_AXI_INTR_ARREADY;
   assign ev32 = 32'(ev);
   assign term = gie & |(isr & ier);
   assign unused_ok = ^{S_AXI_INTR_AWADDR, S_AXI_INTR_ARADDR, S_AXI_INTR_AWPROT, S_AXI_INTR_ARPROT};
   always_comb begin
      wmask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
      clr = (commit && wsel == A_IAR) ? (w_data & wmask) : 32'h0;
      rd_val = rsel == A_GIE ? {31'h0, gie} :
               rsel == A_IER ? ier :
               rsel == A_ISR ? isr :
               rsel == A_IPR ? (isr & ier) : 32'h0;
   end
   always_ff @(posedge S_AXI_INTR_ACLK) begin
      if (!S_AXI_INTR_ARESETN) begin
         aw_full <= 1'b0;
         w_full <= 1'b0;
         aw_word <= 3'h0;
         w_data <= 32'h0;
         w_strb <= 4'h0;
         bvalid <= 1'b0;
         bresp <= RESP_OKAY;
         rvalid <= 1'b0;
         rresp <= RESP_OKAY;
         rdata <= 32'h0;
         gie <= 1'b0;
         ier <= 32'h0;
         isr <= 32'h0;
         term_q <= 1'b0;
         irq_q <= ~C_IRQ_ACTIVE_STATE;
      end else begin
         if (S_AXI_INTR_AWVALID && S_AXI_INTR_AWREADY) begin
            aw_full <= 1'b1;
            aw_word <= S_AXI_INTR_AWADDR[4:2];
         end
         if (S_AXI_INTR_WVALID && S_AXI_INTR_WREADY) begin
            w_full <= 1'b1;
            w_data <= S_AXI_INTR_WDATA;
            w_strb <= S_AXI_INTR_WSTRB;
         end
         if (commit) begin
            bvalid <= 1'b1;
            bresp <= wsel == A_BAD ? RESP_SLVERR : RESP_OKAY;
            if (wsel == A_GIE && w_strb[0]) gie <= w_data[0];
            if (wsel == A_IER) ier <= ((ier & ~wmask) | (w_data & wmask)) & VMASK;
         end else if (bvalid && S_AXI_INTR_BREADY) begin
            bvalid <= 1'b0;
            aw_full <= 1'b0;
            w_full <= 1'b0;
         end
         // Set is ORed in after the clear so a same-cycle event survives an acknowledge.
         isr <= ((isr & ~clr) | ev32) & VMASK;
         if (ar_hs) begin
            rvalid <= 1'b1;
            rdata <= rd_val;
            rresp <= rsel == A_BAD ? RESP_SLVERR : RESP_OKAY;
         end else if (rvalid && S_AXI_INTR_RREADY) begin
            rvalid <= 1'b0;
         end
         term_q <= term;
         irq_q <= (C_IRQ_SENSITIVITY ? term : (term & ~term_q)) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
      end
   end
endmodule

// File: tb/tb_gpio_to_bram_intr_slave.sv
// tb_gpio_to_bram_intr_slave: directed self-checking bench for the interrupt controller slave
module tb_gpio_to_bram_intr_slave;
   logic clk = 1'b0;
   logic aresetn;
   logic [4:0] awaddr, araddr;
   logic [2:0] awprot, arprot;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   logic [0:0] intr_src;
   logic irq;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_to_bram_intr_slave dut (
      .S_AXI_INTR_ACLK(clk),
      .S_AXI_INTR_ARESETN(aresetn),
      .S_AXI_INTR_AWADDR(awaddr),
      .S_AXI_INTR_AWPROT(awprot),
      .S_AXI_INTR_AWVALID(awvalid),
      .S_AXI_INTR_AWREADY(awready),
      .S_AXI_INTR_WDATA(wdata),
      .S_AXI_INTR_WSTRB(wstrb),
      .S_AXI_INTR_WVALID(wvalid),
      .S_AXI_INTR_WREADY(wready),
      .S_AXI_INTR_BRESP(bresp),
      .S_AXI_INTR_BVALID(bvalid),
      .S_AXI_INTR_BREADY(bready),
      .S_AXI_INTR_ARADDR(araddr),
      .S_AXI_INTR_ARPROT(arprot),
      .S_AXI_INTR_ARVALID(arvalid),
      .S_AXI_INTR_ARREADY(arready),
      .S_AXI_INTR_RDATA(rdata),
      .S_AXI_INTR_RRESP(rresp),
      .S_AXI_INTR_RVALID(rvalid),
      .S_AXI_INTR_RREADY(rready),
      .intr_src(intr_src),
      .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
      logic ad, wd;
      int n;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      ad = 1'b0; wd = 1'b0; n = 0;
      while (!(ad && wd) && n < 20) begin
         if (awvalid && awready) ad = 1'b1;
         if (wvalid && wready) wd = 1'b1;
         tick();
         if (ad) awvalid = 1'b0;
         if (wd) wvalid = 1'b0;
         n++;
      end
      n = 0;
      while (!bvalid && n < 20) begin
         tick();
         n++;
      end
      chk("wr_bvalid_seen", bvalid, 1);
      r = bresp;
      tick();
      bready = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
      int n;
      araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      tick();
      arvalid = 1'b0;
      chk("rd_rvalid_seen", rvalid, 1);
      d = rdata; r = rresp;
      tick();
      rready = 1'b0;
   endtask

   task automatic pulse();
      intr_src = 1'b1;
      tick();
      intr_src = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0] r;
      aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = '0; wstrb = '0; intr_src = '0;
      repeat (3) tick();
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_irq", irq, 0);
      aresetn = 1'b1;
      tick();
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);
      chk("post_rst_arready", arready, 1);

      wr(5'h00, 32'h1, 4'hF, r); chk("gie_bresp", r, 2'b00);
      wr(5'h04, 32'h1, 4'hF, r); chk("ier_bresp", r, 2'b00);
      intr_src = 1'b1;
      tick(); intr_src = 1'b0; chk("irq_lat_c1", irq, 0);
      tick(); chk("irq_lat_c2", irq, 0);
      tick(); chk("irq_lat_c3", irq, 1);
      rd(5'h10, d, r); chk("ipr_pending", d, 32'h1); chk("ipr_rresp", r, 2'b00);
      wr(5'h0C, 32'h1, 4'hF, r); chk("ack_irq_low", irq, 0);
      rd(5'h10, d, r); chk("ipr_after_ack", d, 32'h0);
      rd(5'h08, d, r); chk("isr_after_ack", d, 32'h0);

      wr(5'h04, 32'h0, 4'hF, r);
      wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      chk("wfirst_wready", wready, 1);
      tick(); wvalid = 1'b0;
      repeat (3) begin
         tick();
         chk("wfirst_no_b", bvalid, 0);
         chk("wfirst_w_busy", wready, 0);
      end
      chk("wfirst_awready", awready, 1);
      awaddr = 5'h04; awvalid = 1'b1;
      tick(); awvalid = 1'b0;
      chk("wfirst_b_wait", bvalid, 0);
      tick(); chk("wfirst_bvalid", bvalid, 1); chk("wfirst_bresp", bresp, 2'b00);
      tick(); chk("wfirst_b_done", bvalid, 0);
      bready = 1'b0;
      rd(5'h04, d, r); chk("wfirst_ier", d, 32'h1);

      awaddr = 5'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      tick(); awvalid = 1'b0; wvalid = 1'b0;
      tick(); chk("hold_bvalid_rise", bvalid, 1);
      repeat (10) begin
         tick();
         chk("hold_bvalid", bvalid, 1);
         chk("hold_awready", awready, 0);
         chk("hold_wready", wready, 0);
      end
      bready = 1'b1;
      tick(); chk("hold_b_done", bvalid, 0);
      bready = 1'b0;
      rd(5'h04, d, r); chk("hold_ier", d, 32'h0);

      pulse();
      repeat (4) begin
         tick();
         chk("mask_irq_low", irq, 0);
      end
      rd(5'h08, d, r); chk("mask_isr", d, 32'h1);
      rd(5'h10, d, r); chk("mask_ipr", d, 32'h0);
      wr(5'h04, 32'h1, 4'hF, r); chk("unmask_irq", irq, 1);
      wr(5'h00, 32'h0, 4'hF, r); chk("gie_off_irq", irq, 0);
      rd(5'h08, d, r); chk("gie_off_isr", d, 32'h1);
      wr(5'h00, 32'h1, 4'hF, r); chk("gie_on_irq", irq, 1);

      rd(5'h18, d, r); chk("unmap_rdata", d, 32'h0); chk("unmap_rresp", r, 2'b10);
      wr(5'h14, 32'hFFFFFFFF, 4'hF, r); chk("unmap_bresp", r, 2'b10);
      wr(5'h04, 32'h0, 4'h0, r); chk("strb0_bresp", r, 2'b00);
      rd(5'h04, d, r); chk("strb0_ier", d, 32'h1);
      wr(5'h04, 32'h0, 4'hE, r);
      rd(5'h04, d, r); chk("strb_e_ier", d, 32'h1);
      wr(5'h0C, 32'h1, 4'hE, r); chk("iar_unstrobed_irq", irq, 1);
      rd(5'h08, d, r); chk("iar_unstrobed_isr", d, 32'h1);

      intr_src = 1'b1;
      awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      tick(); intr_src = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      tick(); chk("coll_bvalid", bvalid, 1);
      tick(); chk("coll_irq", irq, 1);
      bready = 1'b0;
      rd(5'h08, d, r); chk("coll_isr", d, 32'h1);

      araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
      tick(); arvalid = 1'b0;
      chk("mid_rvalid", rvalid, 1);
      chk("mid_irq", irq, 1);
      aresetn = 1'b0;
      tick();
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_irq", irq, 0);
      chk("mid_rst_arready", arready, 0);
      aresetn = 1'b1;
      tick();
      rd(5'h00, d, r); chk("mid_rst_gie", d, 32'h0);
      rd(5'h04, d, r); chk("mid_rst_ier", d, 32'h0);
      rd(5'h08, d, r); chk("mid_rst_isr", d, 32'h0);
      rd(5'h10, d, r); chk("mid_rst_ipr", d, 32'h0);
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_irq_after", irq, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gpio_to_bram_intr_slave.md
# gpio_to_bram_intr_slave

AXI4-Lite responder implementing the interrupt-controller register bank of the gpio_to_bram IP (the S_AXI_INTR port). It latches edge or level events from up to 32 internal sources, such as capture-done or BRAM-full, into status bits. It masks them with per-source and global enables and drives a single `irq` line to the PS. Software clears status bits through a write-1-to-clear acknowledge register.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; covers offsets 0x00–0x1C.
- C_NUM_OF_INTR, 1, number of interrupt sources, 1–32.
- C_INTR_SENSITIVITY, 32'hFFFFFFFF, per-source mode: 1 = edge, 0 = level.
- C_INTR_ACTIVE_STATE, 32'hFFFFFFFF, per-source active level or edge: 1 = high/rising, 0 = low/falling.
- C_IRQ_SENSITIVITY, 1, irq mode: 1 = level output, 0 = one-cycle pulse.
- C_IRQ_ACTIVE_STATE, 1, asserted polarity of irq.
- S_AXI_INTR_ACLK  in  1  single clock; all logic rises on this edge.
- S_AXI_INTR_ARESETN  in  1  synchronous, active-low reset.
- S_AXI_INTR_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite slave channels with the widths above. PROT is ignored.
- intr_src  in  C_NUM_OF_INTR  raw interrupt sources, synchronous to the clock.
- irq  out  1  interrupt output to the PS.

## Operation
- Register map; bits above C_NUM_OF_INTR read 0:
  - 0x00 GIE: global enable, bit 0, R/W.
  - 0x04 IER: per-source enable, R/W.
  - 0x08 ISR: raw status, RO.
  - 0x0C IAR: acknowledge, write-1-clears the ISR bit; reads 0.
  - 0x10 IPR: pending = ISR & IER, RO.
  - 0x14–0x1C: unmapped. Reads return 0 with RRESP=SLVERR; writes are dropped with BRESP=SLVERR.
- Event detection per source:
  - Edge mode: `intr_src` is registered once; an event is a transition to the active state between consecutive cycles.
  - Level mode: an event is asserted every cycle the source is at its active level.
- ISR[i] sets on an event regardless of IER or GIE. If an event and an IAR write to the same bit occur in the same cycle, set wins.
- WSTRB: only byte lanes with a strobe bit set are written. For IAR, an unstrobed lane clears nothing.
- Level irq = GIE & |IPR, registered. Pulse irq is one cycle, fired on the rising edge of that term.

## Timing
- Reset values: every register and ISR = 0, edge-detect history = 0.
  - AWREADY=WREADY=ARREADY=0 during reset, 1 in the first cycle after reset.
  - BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
  - irq = ~C_IRQ_ACTIVE_STATE.
- Write channel:
  - AW and W are each captured into their own one-entry buffer. A channel's READY is high while its buffer is empty and BVALID=0; the two channels may arrive in either order or together.
  - On the cycle both buffers are full, the register updates and BVALID rises on the next edge.
  - BVALID holds until BREADY; both buffers then free.
  - Only one write is outstanding at a time.
- Read channel:
  - ARREADY=1 while RVALID=0.
  - RDATA is sampled at the AR handshake and RVALID rises the next cycle; RVALID and RDATA hold until RREADY.
  - A read and a write committing to the same register in the same cycle: the read returns the pre-write value.
- Latency from `intr_src` edge to irq:
  - Edge mode: ISR sets 2 cycles after the edge, irq asserts 1 cycle after that.
  - Level mode: 1 cycle less.
- Reset mid-transaction abandons it: no B or R response is issued afterwards.
- GIE cleared while pending: irq deasserts 1 cycle later and ISR is retained. Re-enabling GIE re-asserts irq.

## Structure
- Package gpio_to_bram_intr_pkg holds:
  - register offset constants (GIE/IER/ISR/IAR/IPR);
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10);
  - a typedef for the address-decode enum.
- Sub-module intr_event_detect: handles one source, parameterised by sensitivity and active state, and emits a one-cycle event. It is instantiated C_NUM_OF_INTR times.

## Test plan
- Basic interrupt flow, defaults:
  - Write 0x1→0x00, then 0x1→0x04; BRESP=OKAY.
  - Pulse intr_src[0] for 1 cycle → irq=1 exactly 3 cycles after the edge.
  - Read 0x10 → 0x1.
  - Write 0x1→0x0C → irq=0 next cycle; read 0x10 → 0x0.
- Channel ordering:
  - Present W 4 cycles before AW with data 0x1 to 0x04 → BVALID only after AW is accepted; read 0x04 → 0x1.
  - Repeat with AW/W simultaneous, and with BREADY held low for 10 cycles: BVALID holds and no new AW/W is accepted.
- Masking:
  - With IER=0, pulse the source → read 0x08 = 0x1, 0x10 = 0x0, irq stays 0.
  - Set IER=1 → irq=1 one cycle after the write commits.
  - Clear GIE → irq=0; ISR still reads 0x1.
- Unmapped and strobes:
  - Read 0x18 → RDATA=0, RRESP=2'b10. Write 0x14 → BRESP=2'b10.
  - Write IER with WSTRB=4'b0000 → value unchanged.
- Set/ack collision:
  - Schedule the IAR write commit in the same cycle as an event on source 0 → ISR reads 0x1 afterwards and irq remains 1.
- Reset mid-operation:
  - Assert ARESETN=0 while RVALID=1 and irq=1 → next cycle RVALID=0, irq=~C_IRQ_ACTIVE_STATE, all registers read 0.
